// File: rtl/sobel_gradient.sv
// Sobel gradient stage: 3x3 window from two line buffers, L1 magnitude
// and quantised direction, syncs delayed 5 cycles to match the data.
//   clk, rst_b (async, active-low)
//   vvalid, hvalid, din  : raster input (pixel taken when both valid)
//   fsync, hsync         : vvalid/hvalid delayed by 5 cycles
//   mag, dir             : |Gx|+|Gy| saturated, 0=h 1=+45 2=v 3=-45
module sobel_gradient #(
  parameter int DW = 8,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          vvalid,
  input  logic          hvalid,
  input  logic [DW-1:0] din,
  output logic          fsync,
  output logic          hsync,
  output logic [DW-1:0] mag,
  output logic [1:0]    dir
);

  localparam int SW = DW + 2;
  localparam int PW = SW + 3;

  logic acc;
  assign acc = vvalid & hvalid;

  // position counters
  logic [AW-1:0] col_q;
  logic [10:0]   row_q;
  logic          hv_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      col_q <= '0;
      row_q <= '0;
      hv_q  <= 1'b0;
    end else begin
      hv_q <= hvalid;
      if (!hvalid)
        col_q <= '0;
      else if (acc)
        col_q <= col_q + 1'b1;
      if (!vvalid)
        row_q <= '0;
      else if (hv_q && !hvalid && row_q != '1)
        row_q <= row_q + 1'b1;
    end
  end

  // line buffers; lb1 is fed one cycle late from the registered lb0 read,
  // which gives read-before-write without a second read port on lb0
  logic [DW-1:0] lb0_q [2**AW];
  logic [DW-1:0] lb1_q [2**AW];

  logic [DW-1:0] t0_q, t1_q, t2_q;
  logic [AW-1:0] wa_q;
  logic          v1_q, b1_q;

  always_ff @(posedge clk) begin
    if (acc)
      lb0_q[col_q] <= din;
    if (v1_q)
      lb1_q[wa_q] <= t1_q;
  end

  // stage 1: RAM read, din align
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      t0_q <= '0;
      t1_q <= '0;
      t2_q <= '0;
      wa_q <= '0;
      v1_q <= 1'b0;
      b1_q <= 1'b0;
    end else begin
      v1_q <= acc;
      if (acc) begin
        t0_q <= lb1_q[col_q];
        t1_q <= lb0_q[col_q];
        t2_q <= din;
        wa_q <= col_q;
        b1_q <= (row_q < 11'd2) || (col_q < AW'(2));
      end
    end
  end

  // stage 2: window, p_q[row][col], row 0 oldest, col 2 newest
  logic [DW-1:0] p_q [3][3];
  logic          b2_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          p_q[i][j] <= '0;
      b2_q <= 1'b0;
    end else begin
      b2_q <= b1_q;
      if (v1_q) begin
        for (int i = 0; i < 3; i++) begin
          p_q[i][0] <= p_q[i][1];
          p_q[i][1] <= p_q[i][2];
        end
        p_q[0][2] <= t0_q;
        p_q[1][2] <= t1_q;
        p_q[2][2] <= t2_q;
      end
    end
  end

  // stage 3: weighted edge sums
  logic [SW-1:0] sx0_d, sx2_d, sy0_d, sy2_d;
  logic [SW-1:0] sx0_q, sx2_q, sy0_q, sy2_q;
  logic          b3_q;

  always_comb begin
    sx0_d = SW'(p_q[0][0]) + (SW'(p_q[1][0]) << 1) + SW'(p_q[2][0]);
    sx2_d = SW'(p_q[0][2]) + (SW'(p_q[1][2]) << 1) + SW'(p_q[2][2]);
    sy0_d = SW'(p_q[0][0]) + (SW'(p_q[0][1]) << 1) + SW'(p_q[0][2]);
    sy2_d = SW'(p_q[2][0]) + (SW'(p_q[2][1]) << 1) + SW'(p_q[2][2]);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sx0_q <= '0;
      sx2_q <= '0;
      sy0_q <= '0;
      sy2_q <= '0;
      b3_q  <= 1'b0;
    end else begin
      sx0_q <= sx0_d;
      sx2_q <= sx2_d;
      sy0_q <= sy0_d;
      sy2_q <= sy2_d;
      b3_q  <= b2_q;
    end
  end

  // stage 4: Gx/Gy as sign + magnitude (larger minus smaller is exact)
  logic          xn_d, yn_d, xn_q, yn_q;
  logic [SW-1:0] ax_d, ay_d, ax_q, ay_q;
  logic          b4_q;

  always_comb begin
    xn_d = sx0_q > sx2_q;
    yn_d = sy0_q > sy2_q;
    ax_d = xn_d ? sx0_q - sx2_q : sx2_q - sx0_q;
    ay_d = yn_d ? sy0_q - sy2_q : sy2_q - sy0_q;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      xn_q <= 1'b0;
      yn_q <= 1'b0;
      ax_q <= '0;
      ay_q <= '0;
      b4_q <= 1'b0;
    end else begin
      xn_q <= xn_d;
      yn_q <= yn_d;
      ax_q <= ax_d;
      ay_q <= ay_d;
      b4_q <= b3_q;
    end
  end

  // stage 5: saturate, direction, mask
  logic [SW:0]   m_d;
  logic [PW-1:0] x2_d, y2_d, x5_d, y5_d;
  logic [DW-1:0] mag_d;
  logic [1:0]    dir_d;
  logic          ok_d;
  logic [4:0]    fs_q, hs_q;
  logic [DW-1:0] mag_q;
  logic [1:0]    dir_q;

  always_comb begin
    m_d  = {1'b0, ax_q} + {1'b0, ay_q};
    x2_d = PW'(ax_q) << 1;
    y2_d = PW'(ay_q) << 1;
    x5_d = (PW'(ax_q) << 2) + PW'(ax_q);
    y5_d = (PW'(ay_q) << 2) + PW'(ay_q);
    mag_d = (|m_d[SW:DW]) ? '1 : m_d[DW-1:0];
    if (ax_q == '0 && ay_q == '0)
      dir_d = 2'd0;
    else if (y5_d < x2_d)
      dir_d = 2'd0;
    else if (x5_d < y2_d)
      dir_d = 2'd2;
    else if (xn_q == yn_q)
      dir_d = 2'd1;
    else
      dir_d = 2'd3;
    ok_d = fs_q[3] & hs_q[3] & ~b4_q;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      fs_q  <= '0;
      hs_q  <= '0;
      mag_q <= '0;
      dir_q <= '0;
    end else begin
      fs_q  <= {fs_q[3:0], vvalid};
      hs_q  <= {hs_q[3:0], hvalid};
      mag_q <= ok_d ? mag_d : '0;
      dir_q <= ok_d ? dir_d : 2'd0;
    end
  end

  assign fsync = fs_q[4];
  assign hsync = hs_q[4];
  assign mag   = mag_q;
  assign dir   = dir_q;

endmodule

// File: tb/tb_sobel_gradient.sv
// Bench for sobel_gradient: image-based reference model, expected
// outputs queued at drive time and compared 5 cycles later.
module tb_sobel_gradient;

  localparam int W = 64;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       vvalid, hvalid;
  logic [7:0] din;
  logic       fsync, hsync;
  logic [7:0] mag;
  logic [1:0] dir;

  always #5 clk = ~clk;

  sobel_gradient #(.DW(8), .AW(11)) dut (
    .clk    (clk),
    .rst_b  (rst_b),
    .vvalid (vvalid),
    .hvalid (hvalid),
    .din    (din),
    .fsync  (fsync),
    .hsync  (hsync),
    .mag    (mag),
    .dir    (dir)
  );

  typedef struct packed {
    logic       fs;
    logic       hs;
    logic [7:0] mg;
    logic [1:0] dr;
  } exp_t;

  exp_t sb[$];
  int   img[H][W];
  int   errs = 0;
  int   checks = 0;

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int px(int r, int c);
    return img[r][c];
  endfunction

  function automatic exp_t model(bit v, bit h, int r, int c);
    exp_t e;
    int gx, gy, ax, ay, m;
    e.fs = v;
    e.hs = h;
    e.mg = '0;
    e.dr = '0;
    if (v && h && r >= 2 && c >= 2) begin
      gx = (px(r-2,c) + 2*px(r-1,c) + px(r,c))
         - (px(r-2,c-2) + 2*px(r-1,c-2) + px(r,c-2));
      gy = (px(r,c-2) + 2*px(r,c-1) + px(r,c))
         - (px(r-2,c-2) + 2*px(r-2,c-1) + px(r-2,c));
      ax = gx < 0 ? -gx : gx;
      ay = gy < 0 ? -gy : gy;
      m  = ax + ay;
      e.mg = 8'(m > 255 ? 255 : m);
      if (ax == 0 && ay == 0)      e.dr = 2'd0;
      else if (5*ay < 2*ax)        e.dr = 2'd0;
      else if (5*ax < 2*ay)        e.dr = 2'd2;
      else if ((gx < 0) == (gy < 0)) e.dr = 2'd1;
      else                         e.dr = 2'd3;
    end
    return e;
  endfunction

  task automatic step(bit v, bit h, int r, int c);
    exp_t e;
    vvalid = v;
    hvalid = h;
    din = (v && h) ? 8'(img[r][c]) : 8'($urandom);
    sb.push_back(model(v, h, r, c));
    @(posedge clk);
    #1;
    if (sb.size() >= 5) begin
      e = sb.pop_front();
      check("sync", {30'd0, fsync, hsync}, {30'd0, e.fs, e.hs});
      check("mag", 32'(mag), 32'(e.mg));
      check("dir", 32'(dir), 32'(e.dr));
    end
  endtask

  task automatic fill(int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (kind)
          0: img[r][c] = 100;
          1: img[r][c] = c < 8 ? 0 : 200;
          2: img[r][c] = r < 5 ? 10 : 20;
          3: img[r][c] = (r + c >= 8) ? 40 : 0;
          4: img[r][c] = (r + (W - 1 - c) >= 8) ? 40 : 0;
          default: img[r][c] = int'($urandom_range(0, 255));
        endcase
  endtask

  // nrows/ncols limit how far the frame gets before returning
  task automatic frame(int nrows, int lastcols);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < ((r == nrows - 1) ? lastcols : W); c++)
        step(1, 1, r, c);
      if (r != nrows - 1 || lastcols == W)
        step(1, 0, 0, 0);
    end
  endtask

  task automatic flush();
    repeat (6) step(0, 0, 0, 0);
  endtask

  task automatic outs_zero(string tag);
    check({tag, "_fs"}, 32'(fsync), 32'd0);
    check({tag, "_hs"}, 32'(hsync), 32'd0);
    check({tag, "_mag"}, 32'(mag), 32'd0);
    check({tag, "_dir"}, 32'(dir), 32'd0);
  endtask

  initial begin
    rst_b  = 1'b0;
    vvalid = 1'b0;
    hvalid = 1'b0;
    din    = '0;
    repeat (2) @(posedge clk);
    #1;
    outs_zero("reset");
    rst_b = 1'b1;

    for (int k = 0; k < 6; k++) begin
      fill(k);
      frame(H, W);
      flush();
    end

    // abort mid-line, then a clean frame with fresh data
    fill(5);
    frame(3, 20);
    rst_b = 1'b0;
    #1;
    outs_zero("rst_mid");
    sb.delete();
    vvalid = 1'b0;
    hvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    outs_zero("rst_hold");
    rst_b = 1'b1;
    fill(5);
    frame(H, W);
    flush();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
